// File: rtl/term_writer_if.sv
// Byte-input handshake plus terminal strobed write bus and shadow cursor status.
interface term_writer_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] data;
  logic [1:0] dtype;
  logic       dstrobe;
  logic [4:0] cur_row;
  logic [6:0] cur_col;
  logic       busy;

  modport slave (
    input  in_data, in_valid,
    output in_ready, data, dtype, dstrobe, cur_row, cur_col, busy
  );

  modport master (
    output in_data, in_valid,
    input  in_ready, data, dtype, dstrobe, cur_row, cur_col, busy
  );
endinterface

// File: rtl/term_writer.sv
// Byte-stream front end for the VGA text terminal: interprets printable bytes,
// CR/LF/BS/FF and ESC Y r c, and emits strobed char/column/row writes while
// tracking a shadow of the terminal cursor (30 rows x 80 columns).
module term_writer #(
  parameter int STROBE_HI = 2,
  parameter int STROBE_LO = 2
) (
  input  logic          ck100,
  input  logic          reset_n,
  term_writer_if.slave  bus
);

  localparam int T  = 1 + STROBE_HI + STROBE_LO;
  localparam int TW = $clog2(T + 1);

  localparam logic [1:0] DT_CHR = 2'd0;
  localparam logic [1:0] DT_COL = 2'd1;
  localparam logic [1:0] DT_ROW = 2'd2;

  localparam logic [7:0] B_BS  = 8'h08;
  localparam logic [7:0] B_LF  = 8'h0A;
  localparam logic [7:0] B_FF  = 8'h0C;
  localparam logic [7:0] B_CR  = 8'h0D;
  localparam logic [7:0] B_ESC = 8'h1B;
  localparam logic [7:0] B_Y   = 8'h59;

  typedef enum logic [2:0] {
    S_HOME, S_IDLE, S_ESC, S_ESCY, S_ESCR, S_XFER, S_CLR
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [TW-1:0] r_tcnt;
  logic          r_act;      // a transaction is loaded and running
  logic          r_strobe;
  logic [7:0]    r_data;
  logic [1:0]    r_dtype;
  logic          r_nxt_vld;  // one queued follow-up transaction (col after row)
  logic [7:0]    r_nxt_data;
  logic [1:0]    r_nxt_dtype;
  logic [11:0]   r_clr_cnt;
  logic [4:0]    r_row, r_esc_row;
  logic [6:0]    r_col;

  logic          w_in_ready, w_busy, w_acc, w_print;
  logic          w_run, w_last, w_clr_more, w_more;
  logic [7:0]    w_byte, w_sub;
  logic          w_under;
  logic [4:0]    w_row_cl;
  logic [6:0]    w_col_cl;
  logic          w_ld, w_set_nxt, w_cnt_clr, w_cnt_inc;
  logic [7:0]    w_ld_data, w_nxt_data;
  logic [1:0]    w_ld_type, w_nxt_type;

  assign w_byte  = bus.in_data;
  assign w_acc   = bus.in_valid && w_in_ready;
  assign w_print = (w_byte >= 8'h20) && (w_byte != 8'h7F);

  // Escape coordinates: 8-bit subtract with explicit underflow, then clamp.
  assign w_sub    = w_byte - 8'h20;
  assign w_under  = w_byte < 8'h20;
  assign w_row_cl = w_under ? 5'd0 : ((w_sub > 8'd29) ? 5'd29 : w_sub[4:0]);
  assign w_col_cl = w_under ? 7'd0 : ((w_sub > 8'd79) ? 7'd79 : w_sub[6:0]);

  assign w_run  = r_act && (r_state == S_HOME || r_state == S_XFER || r_state == S_CLR);
  assign w_last = w_run && (r_tcnt == TW'(T - 1));
  // Clear keeps going until the 2400th space (index 2399) has been written.
  assign w_clr_more = (r_state == S_CLR) && ((r_dtype != DT_CHR) || (r_clr_cnt != 12'd2399));
  assign w_more     = r_nxt_vld || w_clr_more;

  // State register.
  always_ff @(posedge ck100 or negedge reset_n) begin
    if (!reset_n) r_state <= S_HOME;
    else          r_state <= w_state_nxt;
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_HOME, S_XFER, S_CLR: if (w_last && !w_more) w_state_nxt = S_IDLE;
      S_IDLE: if (w_acc) begin
        if (w_print || w_byte == B_CR || w_byte == B_LF || (w_byte == B_BS && r_col != 7'd0))
          w_state_nxt = S_XFER;
        else if (w_byte == B_FF)  w_state_nxt = S_CLR;
        else if (w_byte == B_ESC) w_state_nxt = S_ESC;
      end
      S_ESC:  if (w_acc) w_state_nxt = (w_byte == B_Y) ? S_ESCY : S_IDLE;
      S_ESCY: if (w_acc) w_state_nxt = S_ESCR;
      S_ESCR: if (w_acc) w_state_nxt = S_XFER;
      default: w_state_nxt = S_HOME;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    w_in_ready = (r_state == S_IDLE) || (r_state == S_ESC) ||
                 (r_state == S_ESCY) || (r_state == S_ESCR);
    w_busy     = (r_state != S_IDLE);
  end

  // Transaction load decode: what to put on the bus next, and what to queue behind it.
  always_comb begin
    w_ld       = 1'b0;
    w_ld_data  = r_data;
    w_ld_type  = r_dtype;
    w_set_nxt  = 1'b0;
    w_nxt_data = 8'h00;
    w_nxt_type = DT_COL;
    w_cnt_clr  = 1'b0;
    w_cnt_inc  = 1'b0;
    case (r_state)
      // HOME spends one cycle loading so that row(0) is on the bus for its whole S cycle.
      S_HOME: if (!r_act) begin
        w_ld = 1'b1; w_ld_data = 8'h00; w_ld_type = DT_ROW; w_set_nxt = 1'b1;
      end
      S_IDLE: if (w_acc) begin
        if (w_print) begin
          w_ld = 1'b1; w_ld_data = w_byte; w_ld_type = DT_CHR;
        end else if (w_byte == B_CR) begin
          w_ld = 1'b1; w_ld_data = 8'h00; w_ld_type = DT_COL;
        end else if (w_byte == B_LF) begin
          w_ld = 1'b1; w_ld_type = DT_ROW;
          w_ld_data = {3'b000, (r_row == 5'd29) ? 5'd0 : r_row + 5'd1};
        end else if (w_byte == B_BS && r_col != 7'd0) begin
          w_ld = 1'b1; w_ld_type = DT_COL; w_ld_data = {1'b0, r_col - 7'd1};
        end else if (w_byte == B_FF) begin
          w_ld = 1'b1; w_ld_data = 8'h00; w_ld_type = DT_ROW; w_set_nxt = 1'b1;
        end
      end
      S_ESCR: if (w_acc) begin
        w_ld = 1'b1; w_ld_data = {3'b000, r_esc_row}; w_ld_type = DT_ROW;
        w_set_nxt = 1'b1; w_nxt_data = {1'b0, w_col_cl};
      end
      default: ;
    endcase
    // Chain the next transaction straight off the last cycle of the current one.
    if (w_last && w_more) begin
      w_ld = 1'b1;
      if (r_nxt_vld) begin
        w_ld_data = r_nxt_data; w_ld_type = r_nxt_dtype;
      end else begin
        w_ld_data = 8'h20; w_ld_type = DT_CHR;
        if (r_dtype != DT_CHR) w_cnt_clr = 1'b1;
        else                   w_cnt_inc = 1'b1;
      end
    end
  end

  // Transaction engine: phase counter, bus registers, registered strobe, clear counter.
  always_ff @(posedge ck100 or negedge reset_n) begin
    if (!reset_n) begin
      r_tcnt      <= '0;
      r_act       <= 1'b0;
      r_strobe    <= 1'b0;
      r_data      <= 8'h00;
      r_dtype     <= DT_CHR;
      r_nxt_vld   <= 1'b0;
      r_nxt_data  <= 8'h00;
      r_nxt_dtype <= DT_COL;
      r_clr_cnt   <= 12'd0;
    end else begin
      r_strobe <= w_run && !w_last && (r_tcnt < TW'(STROBE_HI));
      if (w_ld) begin
        r_data  <= w_ld_data;
        r_dtype <= w_ld_type;
        r_tcnt  <= '0;
        r_act   <= 1'b1;
      end else if (w_last) begin
        r_tcnt <= '0;
        r_act  <= 1'b0;
      end else if (w_run) begin
        r_tcnt <= r_tcnt + 1'b1;
      end
      if (w_set_nxt) begin
        r_nxt_vld   <= 1'b1;
        r_nxt_data  <= w_nxt_data;
        r_nxt_dtype <= w_nxt_type;
      end else if (w_last && r_nxt_vld) begin
        r_nxt_vld <= 1'b0;
      end
      if (w_cnt_clr)      r_clr_cnt <= 12'd0;
      else if (w_cnt_inc) r_clr_cnt <= r_clr_cnt + 12'd1;
    end
  end

  // Shadow cursor follows each write on its final cycle, mirroring the terminal's wrap.
  always_ff @(posedge ck100 or negedge reset_n) begin
    if (!reset_n) begin
      r_row <= 5'd0;
      r_col <= 7'd0;
    end else if (w_last) begin
      case (r_dtype)
        DT_CHR: if (r_col == 7'd79) begin
          r_col <= 7'd0;
          r_row <= (r_row == 5'd29) ? 5'd0 : r_row + 5'd1;
        end else begin
          r_col <= r_col + 7'd1;
        end
        DT_COL:  r_col <= r_data[6:0];
        DT_ROW:  r_row <= r_data[4:0];
        default: ;
      endcase
    end
  end

  // Latch the clamped row coordinate of an ESC Y sequence.
  always_ff @(posedge ck100 or negedge reset_n) begin
    if (!reset_n)                         r_esc_row <= 5'd0;
    else if (r_state == S_ESCY && w_acc) r_esc_row <= w_row_cl;
  end

  assign bus.in_ready = w_in_ready;
  assign bus.busy     = w_busy;
  assign bus.data     = r_data;
  assign bus.dtype    = r_dtype;
  assign bus.dstrobe  = r_strobe;
  assign bus.cur_row  = r_row;
  assign bus.cur_col  = r_col;

endmodule

// File: tb/tb_term_writer.sv
// Directed bench for term_writer: HOME after reset, strobe timing, a table of
// byte vectors with expected bus writes and shadow cursor, clear screen, reset mid-clear.
module tb_term_writer;
  localparam int HI = 2;
  localparam int LO = 2;
  localparam int T  = 1 + HI + LO;

  logic ck100   = 1'b0;
  logic reset_n = 1'b0;
  term_writer_if bus();

  term_writer #(.STROBE_HI(HI), .STROBE_LO(LO)) dut (
    .ck100  (ck100),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 ck100 = ~ck100;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_fall = 0;
  logic [9:0] pq[$];   // captured writes as {dtype, data}
  bit   prev_s = 1'b0;
  int   hi_w   = 0;

  typedef struct {
    logic [7:0] b;
    int         np;
    logic [9:0] p0;
    logic [9:0] p1;
    logic [4:0] row;
    logic [6:0] col;
  } vec_t;
  vec_t tv[$];

  function automatic logic [9:0] fr(input int x); return {2'd2, 8'(x)}; endfunction
  function automatic logic [9:0] fc(input int x); return {2'd1, 8'(x)}; endfunction
  function automatic logic [9:0] fch(input int x); return {2'd0, 8'(x)}; endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [7:0] b, input int np, input logic [9:0] p0,
                     input logic [9:0] p1, input int r, input int c);
    vec_t v;
    v.b = b; v.np = np; v.p0 = p0; v.p1 = p1; v.row = 5'(r); v.col = 7'(c);
    tv.push_back(v);
  endtask

  always @(posedge ck100) cyc++;

  // Capture each strobe pulse and check its high width.
  always @(negedge ck100) begin
    if (!reset_n) begin
      prev_s = 1'b0;
      hi_w   = 0;
    end else begin
      if (bus.dstrobe) begin
        if (!prev_s) begin
          pq.push_back({bus.dtype, bus.data});
          hi_w = 0;
        end
        hi_w++;
      end else if (prev_s) begin
        last_fall = cyc;
        chk("strobe_hi_width", hi_w, HI);
      end
      prev_s = bus.dstrobe;
    end
  end

  // Present a byte and hold it until in_ready is seen; it is taken on the next rising edge.
  task automatic send(input logic [7:0] b);
    bit ok = 1'b0;
    @(negedge ck100);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 20000; k++) begin
      if (bus.in_ready) begin ok = 1'b1; break; end
      @(negedge ck100);
    end
    if (!ok) chk("send_timeout", 0, 1);
    @(posedge ck100);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic wait_ready(input int budget);
    bit ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge ck100);
      if (bus.in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("ready_timeout", 0, 1);
  endtask

  task automatic goto_rc(input int r, input int c);
    send(8'h1B); send(8'h59); send(8'(r + 32)); send(8'(c + 32));
    wait_ready(100);
  endtask

  initial begin
    logic [5:0] sp, rp;
    int nb, nsp;
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;

    // Reset state.
    repeat (3) @(negedge ck100);
    chk("rst_dstrobe", bus.dstrobe, 0);
    chk("rst_busy", bus.busy, 1);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_data", bus.data, 0);
    chk("rst_dtype", bus.dtype, 0);
    chk("rst_row", bus.cur_row, 0);
    chk("rst_col", bus.cur_col, 0);

    // HOME: row(0) then col(0), in_ready right after the col pulse's low phase.
    reset_n = 1'b1;
    wait_ready(100);
    chk("home_npulse", pq.size(), 2);
    chk("home_p0", pq.size() > 0 ? pq[0] : 10'h3FF, fr(0));
    chk("home_p1", pq.size() > 1 ? pq[1] : 10'h3FF, fc(0));
    chk("home_ready_gap", cyc - last_fall, LO);
    chk("home_row", bus.cur_row, 0);
    chk("home_col", bus.cur_col, 0);

    // Char latency/strobe shape; a second byte held valid while busy is taken once.
    pq.delete();
    send(8'h41);
    bus.in_data  = 8'h5A;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge ck100);
      sp[k] = bus.dstrobe;
      rp[k] = bus.in_ready;
      if (k == 0) begin
        chk("lat_s_dtype", bus.dtype, 0);
        chk("lat_s_data", bus.data, 8'h41);
      end
    end
    @(posedge ck100);
    #1 bus.in_valid = 1'b0;
    chk("lat_strobe_shape", sp, 6'b000110);
    chk("lat_ready_shape", rp, 6'b100000);
    wait_ready(100);
    chk("b2b_npulse", pq.size(), 2);
    chk("b2b_p1", pq.size() > 1 ? pq[1] : 10'h3FF, fch(8'h5A));
    chk("b2b_col", bus.cur_col, 2);

    // Vector table: byte, expected writes, shadow cursor afterwards.
    add(8'h1B, 0, 0, 0, 0, 2);
    add(8'h59, 0, 0, 0, 0, 2);
    add(8'h20, 0, 0, 0, 0, 2);
    add(8'h6F, 2, fr(0), fc(79), 0, 79);
    add(8'h41, 1, fch(8'h41), 0, 1, 0);
    add(8'h1B, 0, 0, 0, 1, 0);
    add(8'h59, 0, 0, 0, 1, 0);
    add(8'h3D, 0, 0, 0, 1, 0);
    add(8'h6F, 2, fr(29), fc(79), 29, 79);
    add(8'h42, 1, fch(8'h42), 0, 0, 0);
    add(8'h1B, 0, 0, 0, 0, 0);
    add(8'h59, 0, 0, 0, 0, 0);
    add(8'h2A, 0, 0, 0, 0, 0);
    add(8'h38, 2, fr(10), fc(24), 10, 24);
    add(8'h1B, 0, 0, 0, 10, 24);
    add(8'h59, 0, 0, 0, 10, 24);
    add(8'h7F, 0, 0, 0, 10, 24);
    add(8'h10, 2, fr(29), fc(0), 29, 0);
    add(8'h1B, 0, 0, 0, 29, 0);
    add(8'h41, 0, 0, 0, 29, 0);
    add(8'hC4, 1, fch(8'hC4), 0, 29, 1);
    add(8'h1B, 0, 0, 0, 29, 1);
    add(8'h59, 0, 0, 0, 29, 1);
    add(8'h25, 0, 0, 0, 29, 1);
    add(8'h23, 2, fr(5), fc(3), 5, 3);
    add(8'h0D, 1, fc(0), 0, 5, 0);
    add(8'h0A, 1, fr(6), 0, 6, 0);
    add(8'h08, 0, 0, 0, 6, 0);
    add(8'h07, 0, 0, 0, 6, 0);
    add(8'h7F, 0, 0, 0, 6, 0);
    add(8'h78, 1, fch(8'h78), 0, 6, 1);
    add(8'h08, 1, fc(0), 0, 6, 0);
    add(8'h1B, 0, 0, 0, 6, 0);
    add(8'h59, 0, 0, 0, 6, 0);
    add(8'h3D, 0, 0, 0, 6, 0);
    add(8'hFF, 2, fr(29), fc(79), 29, 79);
    add(8'h0A, 1, fr(0), 0, 0, 79);
    add(8'h09, 0, 0, 0, 0, 79);

    foreach (tv[i]) begin
      pq.delete();
      send(tv[i].b);
      if (tv[i].np == 0) begin
        @(negedge ck100);
        chk($sformatf("v%0d_ready_next", i), bus.in_ready, 1);
      end
      wait_ready(100);
      chk($sformatf("v%0d_npulse", i), pq.size(), tv[i].np);
      if (tv[i].np > 0) chk($sformatf("v%0d_p0", i), pq.size() > 0 ? pq[0] : 10'h3FF, tv[i].p0);
      if (tv[i].np > 1) chk($sformatf("v%0d_p1", i), pq.size() > 1 ? pq[1] : 10'h3FF, tv[i].p1);
      chk($sformatf("v%0d_row", i), bus.cur_row, tv[i].row);
      chk($sformatf("v%0d_col", i), bus.cur_col, tv[i].col);
    end

    // Clear screen from 7/9.
    goto_rc(7, 9);
    pq.delete();
    send(8'h0C);
    nb = 0;
    @(negedge ck100);
    for (int k = 0; k < 13000; k++) begin
      if (!bus.busy) break;
      nb++;
      @(negedge ck100);
    end
    chk("clr_busy_cycles", nb, 2402 * T);
    chk("clr_ready", bus.in_ready, 1);
    chk("clr_npulse", pq.size(), 2402);
    chk("clr_p0", pq.size() > 0 ? pq[0] : 10'h3FF, fr(0));
    chk("clr_p1", pq.size() > 1 ? pq[1] : 10'h3FF, fc(0));
    nsp = 0;
    for (int k = 2; k < pq.size(); k++) if (pq[k] == fch(8'h20)) nsp++;
    chk("clr_spaces", nsp, 2400);
    chk("clr_row", bus.cur_row, 0);
    chk("clr_col", bus.cur_col, 0);

    // Reset in the middle of a clear, while dstrobe is high on the 1000th space.
    goto_rc(3, 3);
    pq.delete();
    send(8'h0C);
    begin
      bit hit = 1'b0;
      for (int k = 0; k < 8000; k++) begin
        @(negedge ck100);
        if (pq.size() >= 1002 && bus.dstrobe) begin hit = 1'b1; break; end
      end
      if (!hit) chk("midclr_reach", 0, 1);
    end
    reset_n = 1'b0;
    #1;
    chk("midclr_strobe_drop", bus.dstrobe, 0);
    chk("midclr_row", bus.cur_row, 0);
    chk("midclr_col", bus.cur_col, 0);
    repeat (3) @(negedge ck100);
    pq.delete();
    reset_n = 1'b1;
    wait_ready(100);
    repeat (20) @(negedge ck100);
    chk("midclr_npulse", pq.size(), 2);
    chk("midclr_p0", pq.size() > 0 ? pq[0] : 10'h3FF, fr(0));
    chk("midclr_p1", pq.size() > 1 ? pq[1] : 10'h3FF, fc(0));
    chk("midclr_idle", bus.busy, 0);
    chk("midclr_row2", bus.cur_row, 0);
    chk("midclr_col2", bus.cur_col, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
